mmu_xlate: RTL and testbench

//  Two-stage virtual-to-physical translation pipe between a CPU memory stage and the tlb search port.
//  S1 registers the request and drives the tlb search port; S2 registers paddr, cacheability and exception.

---
 rtl/cpu_defs.sv | 27 ++
 rtl/mmu_region_dec.sv | 30 +++
 rtl/mmu_xlate.sv | 169 ++++++++++++++++
 tb/tb_mmu_xlate.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_defs : shared translation codes and address-region constants     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cpu_defs;

  localparam logic [1:0] XL_EX_NONE     = 2'd0;
  localparam logic [1:0] XL_EX_REFILL   = 2'd1;
  localparam logic [1:0] XL_EX_INVALID  = 2'd2;
  localparam logic [1:0] XL_EX_MODIFIED = 2'd3;

  localparam logic [2:0] CACHE_UNCACHED = 3'd2;
  localparam logic [2:0] KSEG0          = 3'b100;
  localparam logic [2:0] KSEG1          = 3'b101;

  // Refill outranks invalid, which outranks a dirty violation on stores.
  function automatic logic [1:0] xl_classify(input logic found, input logic v,
                                             input logic wr, input logic d);
    if (!found)        return XL_EX_REFILL;
    else if (!v)       return XL_EX_INVALID;
    else if (wr && !d) return XL_EX_MODIFIED;
    else               return XL_EX_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmu_region_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmu_region_dec : vaddr[31:29] region decode -> mapped flag and the   |
// |                  cacheability attribute used for unmapped accesses   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mmu_region_dec
  import cpu_defs::*;
#(
  parameter int MAP_EN = 1
) (
  input  logic [2:0] vregion,
  input  logic [2:0] cfg_k0,
  output logic       mapped,
  output logic [2:0] attr
);

  always_comb begin
    mapped = 1'b0;
    attr   = cfg_k0;
    if (MAP_EN != 0) begin
      if (vregion == KSEG1)
        attr = CACHE_UNCACHED;
      else if (vregion != KSEG0)
        mapped = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mmu_xlate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmu_xlate : two-stage virtual-to-physical translation pipe; S1 holds |
// |             the request and drives tlb search, S2 holds the result   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mmu_xlate
  import cpu_defs::*;
#(
  parameter  int TLBNUM = 16,
  parameter  int MAP_EN = 1,
  localparam int IW     = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_vaddr,
  input  logic          req_wr,
  input  logic [7:0]    cur_asid,
  input  logic [2:0]    cfg_k0,
  output logic [18:0]   s_vpn2,
  output logic          s_odd_page,
  output logic [7:0]    s_asid,
  input  logic          s_found,
  input  logic [IW-1:0] s_index,
  input  logic [19:0]   s_pfn,
  input  logic [2:0]    s_c,
  input  logic          s_d,
  input  logic          s_v,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_paddr,
  output logic          rsp_uncached,
  output logic          rsp_ex,
  output logic [1:0]    rsp_excode,
  output logic          rsp_wr,
  output logic [31:0]   rsp_badvaddr,
  output logic [IW-1:0] rsp_index
);

  logic          r_s1_valid;
  logic [31:0]   r_s1_vaddr;
  logic          r_s1_wr;
  logic [7:0]    r_s1_asid;
  logic [2:0]    r_s1_k0;

  logic          r_s2_valid;
  logic [31:0]   r_s2_paddr;
  logic          r_s2_uncached;
  logic          r_s2_ex;
  logic [1:0]    r_s2_excode;
  logic          r_s2_wr;
  logic [31:0]   r_s2_badvaddr;
  logic [IW-1:0] r_s2_index;

  logic          w_s2_adv;
  logic          w_s1_adv;
  logic          w_accept;
  logic          w_capture;
  logic          w_mapped;
  logic [2:0]    w_unmap_attr;
  logic [2:0]    w_attr;
  logic [31:0]   w_paddr;
  logic [1:0]    w_excode;
  logic          w_ex;
  logic          w_uncached;
  logic [IW-1:0] w_index;

  assign w_s2_adv  = ~r_s2_valid | rsp_ready;
  assign w_s1_adv  = ~r_s1_valid | w_s2_adv;
  assign req_ready = w_s1_adv & ~flush;
  assign w_accept  = req_valid & req_ready;
  assign w_capture = w_s2_adv & r_s1_valid & ~flush;

  mmu_region_dec #(
    .MAP_EN (MAP_EN)
  ) u_region_dec (
    .vregion (r_s1_vaddr[31:29]),
    .cfg_k0  (r_s1_k0),
    .mapped  (w_mapped),
    .attr    (w_unmap_attr)
  );

  // Result is evaluated live from S1 so a stalled request sees tlb updates.
  always_comb begin
    w_paddr  = {3'b000, r_s1_vaddr[28:0]};
    w_attr   = w_unmap_attr;
    w_excode = XL_EX_NONE;
    w_index  = '0;
    if (w_mapped) begin
      w_attr   = s_c;
      w_excode = xl_classify(s_found, s_v, r_s1_wr, s_d);
      if (s_found)
        w_index = s_index;
      if (w_excode != XL_EX_NONE)
        w_paddr = '0;
      else
        w_paddr = {s_pfn, r_s1_vaddr[11:0]};
    end
    w_ex       = (w_excode != XL_EX_NONE);
    w_uncached = ~w_ex & (w_attr == CACHE_UNCACHED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_vaddr <= '0;
      r_s1_wr    <= 1'b0;
      r_s1_asid  <= '0;
      r_s1_k0    <= '0;
    end else begin
      if (flush)
        r_s1_valid <= 1'b0;
      else if (w_s1_adv)
        r_s1_valid <= req_valid;
      if (w_accept) begin
        r_s1_vaddr <= req_vaddr;
        r_s1_wr    <= req_wr;
        r_s1_asid  <= cur_asid;
        r_s1_k0    <= cfg_k0;
      end
    end
  end

  // S2 data moves only on capture, so rsp_* never toggles while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid    <= 1'b0;
      r_s2_paddr    <= '0;
      r_s2_uncached <= 1'b0;
      r_s2_ex       <= 1'b0;
      r_s2_excode   <= XL_EX_NONE;
      r_s2_wr       <= 1'b0;
      r_s2_badvaddr <= '0;
      r_s2_index    <= '0;
    end else begin
      if (flush)
        r_s2_valid <= 1'b0;
      else if (w_s2_adv)
        r_s2_valid <= r_s1_valid;
      if (w_capture) begin
        r_s2_paddr    <= w_paddr;
        r_s2_uncached <= w_uncached;
        r_s2_ex       <= w_ex;
        r_s2_excode   <= w_excode;
        r_s2_wr       <= r_s1_wr;
        r_s2_badvaddr <= r_s1_vaddr;
        r_s2_index    <= w_index;
      end
    end
  end

  assign s_vpn2       = r_s1_vaddr[31:13];
  assign s_odd_page   = r_s1_vaddr[12];
  assign s_asid       = r_s1_asid;

  assign rsp_valid    = r_s2_valid;
  assign rsp_paddr    = r_s2_paddr;
  assign rsp_uncached = r_s2_uncached;
  assign rsp_ex       = r_s2_ex;
  assign rsp_excode   = r_s2_excode;
  assign rsp_wr       = r_s2_wr;
  assign rsp_badvaddr = r_s2_badvaddr;
  assign rsp_index    = r_s2_index;

endmodule
`default_nettype wire

// File: tb/tb_mmu_xlate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mmu_xlate : scoreboard bench with a behavioural tlb and reference |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mmu_xlate;

  typedef struct packed {
    logic [31:0] paddr;
    logic        uncached;
    logic        ex;
    logic [1:0]  excode;
    logic        wr;
    logic [31:0] badvaddr;
    logic [3:0]  index;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset, flush, req_valid, req_ready, req_wr;
  logic [31:0] req_vaddr;
  logic [7:0]  cur_asid;
  logic [2:0]  cfg_k0;
  logic [18:0] s_vpn2;
  logic        s_odd_page;
  logic [7:0]  s_asid;
  logic        s_found, s_d, s_v;
  logic [3:0]  s_index;
  logic [19:0] s_pfn;
  logic [2:0]  s_c;
  logic        rsp_valid, rsp_ready, rsp_uncached, rsp_ex, rsp_wr;
  logic [31:0] rsp_paddr, rsp_badvaddr;
  logic [1:0]  rsp_excode;
  logic [3:0]  rsp_index;

  int   n_checks = 0;
  int   n_fail   = 0;
  rsp_t q[$];
  rsp_t pend;
  logic last_rr;

  logic        t_use [16];
  logic        t_g   [16];
  logic [18:0] t_vpn2[16];
  logic [7:0]  t_asid[16];
  logic [19:0] t_pfn [16][2];
  logic [2:0]  t_c   [16][2];
  logic        t_d   [16][2];
  logic        t_v   [16][2];

  always #5 clk = ~clk;

  mmu_xlate #(.TLBNUM(16), .MAP_EN(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .req_wr(req_wr), .cur_asid(cur_asid), .cfg_k0(cfg_k0),
    .s_vpn2(s_vpn2), .s_odd_page(s_odd_page), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index), .s_pfn(s_pfn), .s_c(s_c),
    .s_d(s_d), .s_v(s_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_paddr(rsp_paddr),
    .rsp_uncached(rsp_uncached), .rsp_ex(rsp_ex), .rsp_excode(rsp_excode),
    .rsp_wr(rsp_wr), .rsp_badvaddr(rsp_badvaddr), .rsp_index(rsp_index)
  );

  // Behavioural tlb answering the search port, first matching entry wins.
  always_comb begin : tlb_search
    logic hit;
    hit = 1'b0;
    s_found = 1'b0; s_index = '0; s_pfn = '0; s_c = '0; s_d = 1'b0; s_v = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!hit && t_use[i] && t_vpn2[i] == s_vpn2 && (t_g[i] || t_asid[i] == s_asid)) begin
        hit = 1'b1;
        s_found = 1'b1;
        s_index = 4'(i);
        s_pfn = t_pfn[i][s_odd_page];
        s_c = t_c[i][s_odd_page];
        s_d = t_d[i][s_odd_page];
        s_v = t_v[i][s_odd_page];
      end
    end
  end

  function automatic rsp_t model(input logic [31:0] va, input logic wr,
                                 input logic [7:0] asid, input logic [2:0] k0);
    rsp_t r;
    int   hit;
    int   pg;
    r = '0;
    r.wr = wr;
    r.badvaddr = va;
    if (va >= 32'h8000_0000 && va < 32'hA000_0000) begin
      r.paddr = va - 32'h8000_0000;
      r.uncached = (k0 == 3'd2);
      return r;
    end
    if (va >= 32'hA000_0000 && va < 32'hC000_0000) begin
      r.paddr = va - 32'hA000_0000;
      r.uncached = 1'b1;
      return r;
    end
    hit = -1;
    for (int i = 0; i < 16; i++)
      if (hit < 0 && t_use[i] && t_vpn2[i] == 19'(va / 32'd8192) && (t_g[i] || t_asid[i] == asid))
        hit = i;
    if (hit < 0) begin
      r.ex = 1'b1; r.excode = 2'd1;
      return r;
    end
    r.index = 4'(hit);
    pg = int'((va / 32'd4096) % 32'd2);
    if (!t_v[hit][pg]) begin
      r.ex = 1'b1; r.excode = 2'd2;
    end else if (wr && !t_d[hit][pg]) begin
      r.ex = 1'b1; r.excode = 2'd3;
    end else begin
      r.paddr = 32'(t_pfn[hit][pg]) * 32'd4096 + (va % 32'd4096);
      r.uncached = (t_c[hit][pg] == 3'd2);
    end
    return r;
  endfunction

  function automatic rsp_t mk(input logic [31:0] pa, input logic unc, input logic [1:0] code,
                              input logic wr, input logic [31:0] va, input logic [3:0] idx);
    rsp_t r;
    r.paddr = pa; r.uncached = unc; r.ex = (code != 2'd0); r.excode = code;
    r.wr = wr; r.badvaddr = va; r.index = idx;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [72:0] act, input logic [72:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold behaviour.
  rsp_t cur, prev_d, exp_r;
  bit   have_prev = 1'b0;
  bit   prev_stall = 1'b0;
  always @(negedge clk) begin
    cur = {rsp_paddr, rsp_uncached, rsp_ex, rsp_excode, rsp_wr, rsp_badvaddr, rsp_index};
    if (reset) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev && (!rsp_valid || prev_stall))
        chk("rsp_hold", cur, prev_d);
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", 73'(rsp_valid), 73'd0);
        end else begin
          exp_r = q.pop_front();
          chk("rsp_data", cur, exp_r);
        end
      end
      prev_d = cur;
      prev_stall = rsp_valid && !rsp_ready;
      have_prev = 1'b1;
    end
  end

  task automatic step(output bit acc);
    @(negedge clk);
    acc = req_valid && req_ready;
    last_rr = req_ready;
    if (flush) q.delete();
    else if (acc) q.push_back(pend);
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] va, input logic wr, input logic [7:0] asid, input rsp_t e);
    req_valid = 1'b1; req_vaddr = va; req_wr = wr; cur_asid = asid; pend = e;
  endtask

  task automatic send_one(input logic [31:0] va, input logic wr, input logic [7:0] asid, input rsp_t e);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    present(va, wr, asid, e);
    while (!acc && n < 50) begin
      step(acc);
      n++;
    end
    req_valid = 1'b0;
    if (!acc) chk("send_timeout", 73'd0, 73'd1);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((q.size() != 0 || rsp_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, 73'(q.size()), 73'd0);
  endtask

  task automatic tlb_clear();
    for (int i = 0; i < 16; i++) begin
      t_use[i] = 1'b0; t_g[i] = 1'b0; t_vpn2[i] = '0; t_asid[i] = '0;
      for (int p = 0; p < 2; p++) begin
        t_pfn[i][p] = '0; t_c[i][p] = '0; t_d[i][p] = 1'b0; t_v[i][p] = 1'b0;
      end
    end
  endtask

  function automatic logic [31:0] rand_vaddr(output logic [7:0] asid);
    int unsigned sel, k, top;
    sel = $urandom % 8;
    asid = 8'($urandom);
    if (sel < 2) return {3'b100, 29'($urandom)};
    if (sel == 2) return {3'b101, 29'($urandom)};
    if (sel == 3) begin
      top = $urandom % 6;
      if (top >= 4) top += 2;
      return {3'(top), 29'($urandom)};
    end
    k = $urandom % 16;
    if ($urandom % 2 == 0) asid = t_asid[k];
    return {t_vpn2[k], 13'($urandom)};
  endfunction

  initial begin
    bit acc;
    int idx;
    logic [31:0] va;
    logic [7:0]  asid;
    logic        wr;
    logic [31:0] b2b_va [4];
    tlb_clear();
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_vaddr = '0; req_wr = 1'b0;
    cur_asid = '0; cfg_k0 = 3'd3; rsp_ready = 1'b1; pend = '0; last_rr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", 73'(rsp_valid), 73'd0);
    chk("reset_rsp_data", {rsp_paddr, rsp_uncached, rsp_ex, rsp_excode, rsp_wr, rsp_badvaddr, rsp_index}, 73'd0);
    chk("reset_search", 73'({s_vpn2, s_odd_page, s_asid}), 73'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // kseg1 request through an empty pipe: response two registers later
    present(32'hBFC0_0000, 1'b0, 8'd0, mk(32'h1FC0_0000, 1'b1, 2'd0, 1'b0, 32'hBFC0_0000, 4'd0));
    step(acc);
    req_valid = 1'b0;
    chk("first_accept", 73'(acc), 73'd1);
    @(negedge clk);
    chk("lat_s1_only", 73'(rsp_valid), 73'd0);
    @(negedge clk);
    chk("lat_s2_valid", 73'(rsp_valid), 73'd1);
    @(posedge clk); #1;
    drain("drain_kseg1");

    send_one(32'h8000_1234, 1'b0, 8'd0, mk(32'h0000_1234, 1'b0, 2'd0, 1'b0, 32'h8000_1234, 4'd0));

    t_use[0] = 1'b1; t_vpn2[0] = 19'h00201; t_asid[0] = 8'd5;
    t_pfn[0][0] = 20'h12345; t_c[0][0] = 3'd2; t_v[0][0] = 1'b1; t_d[0][0] = 1'b0;
    t_use[1] = 1'b1; t_vpn2[1] = 19'h00300; t_asid[1] = 8'd5; t_v[1][0] = 1'b0; t_d[1][0] = 1'b1;
    send_one(32'h0040_2000, 1'b0, 8'd5, mk(32'h1234_5000, 1'b1, 2'd0, 1'b0, 32'h0040_2000, 4'd0));
    send_one(32'h0040_2000, 1'b1, 8'd5, mk(32'h0, 1'b0, 2'd3, 1'b1, 32'h0040_2000, 4'd0));
    send_one(32'h0700_0ABC, 1'b1, 8'd5, mk(32'h0, 1'b0, 2'd1, 1'b1, 32'h0700_0ABC, 4'd0));
    send_one(32'h0060_0010, 1'b1, 8'd5, mk(32'h0, 1'b0, 2'd2, 1'b1, 32'h0060_0010, 4'd1));
    send_one(32'h0040_2000, 1'b0, 8'd6, mk(32'h0, 1'b0, 2'd1, 1'b0, 32'h0040_2000, 4'd0));
    drain("drain_directed");

    // back-to-back with the consumer stalled: two fit, then backpressure
    for (int i = 0; i < 4; i++) b2b_va[i] = 32'hA000_0100 + 32'(i) * 32'h40;
    rsp_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      present(b2b_va[idx], 1'b0, 8'd0, mk(b2b_va[idx] - 32'hA000_0000, 1'b1, 2'd0, 1'b0, b2b_va[idx], 4'd0));
      step(acc);
      if (acc) idx++;
    end
    chk("b2b_accepted", 73'(idx), 73'd2);
    chk("b2b_req_ready", 73'(last_rr), 73'd0);
    rsp_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      present(b2b_va[idx], 1'b0, 8'd0, mk(b2b_va[idx] - 32'hA000_0000, 1'b1, 2'd0, 1'b0, b2b_va[idx], 4'd0));
      step(acc);
      if (acc) idx++;
    end
    req_valid = 1'b0;
    chk("b2b_all_accepted", 73'(idx), 73'd4);
    drain("drain_b2b");

    // flush with both stages occupied
    rsp_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10 && idx < 2; c++) begin
      present(32'h8000_0040, 1'b0, 8'd0, mk(32'h40, 1'b0, 2'd0, 1'b0, 32'h8000_0040, 4'd0));
      step(acc);
      if (acc) idx++;
    end
    flush = 1'b1;
    present(32'h8000_0080, 1'b0, 8'd0, mk(32'h80, 1'b0, 2'd0, 1'b0, 32'h8000_0080, 4'd0));
    step(acc);
    chk("flush_req_ready", 73'(last_rr), 73'd0);
    chk("flush_no_accept", 73'(acc), 73'd0);
    flush = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("flush_rsp_valid", 73'(rsp_valid), 73'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    repeat (5) step(acc);
    drain("drain_flush");

    // randomized traffic against the reference model
    for (int i = 0; i < 16; i++) begin
      int unsigned top;
      top = $urandom % 6;
      if (top >= 4) top += 2;
      t_use[i] = ($urandom % 8) != 0;
      t_g[i] = ($urandom % 4) == 0;
      t_vpn2[i] = {3'(top), 12'($urandom), 4'(i)};
      t_asid[i] = 8'($urandom);
      for (int p = 0; p < 2; p++) begin
        t_pfn[i][p] = 20'($urandom);
        t_c[i][p] = 3'($urandom);
        t_d[i][p] = 1'($urandom);
        t_v[i][p] = ($urandom % 5) != 0;
      end
    end
    cfg_k0 = 3'($urandom);
    for (int c = 0; c < 500; c++) begin
      flush = ($urandom % 40) == 0;
      rsp_ready = flush ? 1'b0 : (($urandom % 4) != 0);
      va = rand_vaddr(asid);
      wr = 1'($urandom);
      present(va, wr, asid, model(va, wr, asid, cfg_k0));
      req_valid = ($urandom % 3) != 0;
      step(acc);
    end
    flush = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain("drain_random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
